seg_carry_adder: RTL and testbench
==================================

SEG_CARRY_ADDER -- requirements
Module: seg_carry_adder

Interface
REQ-001 Parameter WIDTH, default 32: total operand/result width in bits.
REQ-002 Parameter SEG, default 8: bits per segment (one carry-chain pass per cycle); NSEG = WIDTH/SEG.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 bi  input  1  invert B before addition.
REQ-010 ci  input  1  carry-in to bit 0.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 y  output  WIDTH  sum.
REQ-014 x  output  WIDTH  propagate vector a ^ bb.
REQ-015 co  output  1  carry out of bit WIDTH-1.
REQ-016 ov  output  1  two's-complement signed overflow.

Function
REQ-017 Elaboration SHALL fail if SEG < 1, SEG > WIDTH, or WIDTH mod SEG != 0.
REQ-018 Arithmetic: bb = bi ? ~b : b; {co, y} = a + bb + ci, widths zero-extended to WIDTH+1; x = a ^ bb; ov = (a[MSB] == bb[MSB]) && (y[MSB] != a[MSB]).
REQ-019 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-020 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is DONE.
REQ-021 IDLE: on in_valid && in_ready, latch a, bb, ci into internal registers, seg counter := 0, carry register := ci, go RUN; otherwise stay.
REQ-022 RUN, each cycle: add segment k bits of latched a and bb plus carry register; write SEG-bit sum into y segment k and x segment k; carry register := segment carry-out; k := k+1.
REQ-023 RUN exit: on the cycle processing k = NSEG-1, also capture co := segment carry-out, compute ov from MSB bits, go DONE.
REQ-024 Latency: out_valid SHALL rise exactly NSEG cycles after the accepting edge (4 with defaults); NSEG=1 gives 1.
REQ-025 Inputs a, b, bi, ci SHALL be ignored outside the accepting cycle; changes during RUN/DONE do not affect the result.
REQ-026 DONE: y, x, co, ov held stable while out_ready = 0; on out_ready = 1 go IDLE next edge.
REQ-027 No same-cycle turnaround: in_ready is 0 in the DONE->IDLE handoff cycle; next operand accepted no earlier than the cycle after out_valid falls.
REQ-028 y/x segments not yet written during RUN SHALL keep their reset/previous values; only DONE values are architecturally meaningful.
REQ-029 Segment counter SHALL be ceil(log2(NSEG+1)) bits minimum and never exceed NSEG-1 in RUN.
REQ-030 Carry SHALL propagate only through the registered carry between segments; no combinational path from a/b to y.

Reset
REQ-031 With rst = 1 at a rising edge: state := IDLE, counter := 0, carry := 0, y := 0, x := 0, co := 0, ov := 0.
REQ-032 After reset, out_valid = 0 and in_ready = 1 in the following cycle.
REQ-033 Reset in RUN or DONE SHALL abandon the operation with no partial result delivered; rst dominates in_valid and out_ready in the same cycle.

Verification
REQ-034 a=0x000000FF, b=0x00000001, bi=0, ci=0 -> y=0x00000100, co=0, ov=0, out_valid exactly 4 cycles after accept (inter-segment carry).
REQ-035 a=0xFFFFFFFF, b=0x00000001, bi=0, ci=0 -> y=0x00000000, x=0xFFFFFFFE, co=1, ov=0.
REQ-036 a=5, b=7, bi=1, ci=1 -> y=0xFFFFFFFE, co=0, ov=0; a=7, b=5, bi=1, ci=1 -> y=2, co=1.
REQ-037 a=0x7FFFFFFF, b=1, bi=0, ci=0 -> y=0x80000000, ov=1, co=0.
REQ-038 Hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> y stable, in_ready=0, new operands not taken; release -> IDLE next cycle, then accepted.
REQ-039 Assert rst during RUN at k=2 -> next cycle out_valid=0, in_ready=1, y=0, co=0; following operand computes correctly.

Source files
------------

// File: rtl/seg_carry_adder.sv
// Multi-cycle adder: one SEG-bit carry-chain pass per clock, with the carry
// between segments held in a register. Results are handed off with a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for an operand set (in_ready = 1)
// RUN    | adding one segment per cycle, low segment first
// DONE   | result held until the consumer takes it (out_valid = 1)
module seg_carry_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] x,
  output logic             co,
  output logic             ov
);

  localparam int SEG_SAFE = (SEG >= 1) ? SEG : 1;
  localparam int NSEG     = WIDTH / SEG_SAFE;
  localparam int CW       = $clog2(NSEG + 1);
  localparam int MSB      = WIDTH - 1;

  generate
    if (SEG < 1 || SEG > WIDTH || (WIDTH % SEG_SAFE) != 0) begin : g_bad_param
      $fatal(1, "seg_carry_adder: SEG must be in 1..WIDTH and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_bb;
  logic               r_carry;
  logic [CW-1:0]      r_k;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_x;
  logic               r_co;
  logic               r_ov;

  logic [WIDTH-1:0]   w_bb;
  logic               w_last;
  logic [SEG_SAFE-1:0] w_seg_a;
  logic [SEG_SAFE-1:0] w_seg_b;
  logic [SEG_SAFE:0]   w_seg_sum;
  logic [SEG_SAFE-1:0] w_seg_x;

  assign w_bb   = bi ? ~b : b;
  assign w_last = (r_k == CW'(NSEG - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Select segment k of the latched operands; only registers feed the adder.
  always_comb begin
    w_seg_a = '0;
    w_seg_b = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (r_k == CW'(i)) begin
        w_seg_a = r_a[i*SEG_SAFE +: SEG_SAFE];
        w_seg_b = r_bb[i*SEG_SAFE +: SEG_SAFE];
      end
    end
    w_seg_sum = {1'b0, w_seg_a} + {1'b0, w_seg_b} + (SEG_SAFE + 1)'(r_carry);
    w_seg_x   = w_seg_a ^ w_seg_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_bb    <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_y     <= '0;
      r_x     <= '0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_bb    <= w_bb;
            r_carry <= ci;
            r_k     <= '0;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NSEG; i++) begin
            if (r_k == CW'(i)) begin
              r_y[i*SEG_SAFE +: SEG_SAFE] <= w_seg_sum[SEG_SAFE-1:0];
              r_x[i*SEG_SAFE +: SEG_SAFE] <= w_seg_x;
            end
          end
          r_carry <= w_seg_sum[SEG_SAFE];
          if (w_last) begin
            r_co <= w_seg_sum[SEG_SAFE];
            r_ov <= (r_a[MSB] == r_bb[MSB]) && (w_seg_sum[SEG_SAFE-1] != r_a[MSB]);
          end else begin
            r_k <= r_k + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign y  = r_y;
  assign x  = r_x;
  assign co = r_co;
  assign ov = r_ov;

endmodule

// File: tb/tb_seg_carry_adder.sv
// Scoreboard bench for seg_carry_adder: directed vectors with hand-computed
// results, plus handshake-hold and mid-run reset scenarios.
module tb_seg_carry_adder;

  localparam int W    = 32;
  localparam int NSEG = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [W-1:0] x;
  logic         co;
  logic         ov;

  seg_carry_adder #(.WIDTH(W), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bi(bi), .ci(ci),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .x(x), .co(co), .ov(ov)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    logic [W-1:0] x;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic         ci;
    logic [W-1:0] y;
    logic [W-1:0] x;
    logic         co;
    logic         ov;
  } vec_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pop the scoreboard on the first cycle of every out_valid pulse.
  initial begin : monitor
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(y), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          check("y", 64'(y), 64'(e.y));
          check("x", 64'(x), 64'(e.x));
          check("co", 64'(co), 64'(e.co));
          check("ov", 64'(ov), 64'(e.ov));
          check("latency", 64'(cyc - e.acc), 64'(NSEG));
        end
      end else if (!out_valid) begin
        seen = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic release_out(input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.y = v.y; e.x = v.x; e.co = v.co; e.ov = v.ov; e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic send(input vec_t v, input int hold);
    wait_ready();
    in_valid = 1'b1; a = v.a; b = v.b; bi = v.bi; ci = v.ci;
    @(posedge clk);
    #1;
    push_exp(v);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bi = 1'($urandom); ci = 1'($urandom);
    @(negedge clk);
    wait_valid();
    release_out(hold);
  endtask

  vec_t vecs[8];

  initial begin
    vec_t v9, v10;
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 32'h000000FE, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0};
    vecs[3] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 32'hFFFFFFFD, 1'b1, 1'b0};
    vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFE, 1'b0, 1'b1};
    vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b1};
    vecs[6] = '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 32'h03254769, 1'b0, 1'b0};
    vecs[7] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 32'h00FE00FE, 1'b0, 1'b0};
    v9      = '{32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0, 32'h10101010, 32'h0E0E0E0E, 1'b0, 1'b0};
    v10     = '{32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 32'h00000000, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bi = 1'b0; ci = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_y", 64'(y), 64'd0);
    check("rst_co", 64'(co), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) send(vecs[i], i % 3);

    // Consumer stalls for 3 cycles while new operands are already offered.
    wait_ready();
    in_valid = 1'b1; a = v9.a; b = v9.b; bi = v9.bi; ci = v9.ci;
    @(posedge clk);
    #1;
    push_exp(v9);
    a = v10.a; b = v10.b; bi = v10.bi; ci = v10.ci;
    @(negedge clk);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_y", 64'(y), 64'(v9.y));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("handoff_in_ready", 64'(in_ready), 64'd1);
    check("handoff_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    push_exp(v10);
    in_valid = 1'b0;
    @(negedge clk);
    wait_valid();
    release_out(0);

    // Reset while the third segment (k=2) is being processed.
    wait_ready();
    in_valid = 1'b1; a = vecs[1].a; b = vecs[1].b; bi = vecs[1].bi; ci = vecs[1].ci;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_y", 64'(y), 64'd0);
    check("abort_x", 64'(x), 64'd0);
    check("abort_co", 64'(co), 64'd0);

    send(vecs[4], 1);
    send(vecs[0], 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
